// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port register-input memory.
// Optional MEM_ARB_BOUND_CHECK_EN turns addresses >= SIZE into error responses with no memory command.
module mem_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req_valid,
    output logic             p0_req_ready,
    input  logic             p0_req_we,
    input  logic [31:0]      p0_req_addr,
    input  logic [WIDTH-1:0] p0_req_wdata,
    output logic             p0_rsp_valid,
    output logic [WIDTH-1:0] p0_rsp_rdata,
    output logic             p0_rsp_err,
    input  logic             p1_req_valid,
    output logic             p1_req_ready,
    input  logic             p1_req_we,
    input  logic [31:0]      p1_req_addr,
    input  logic [WIDTH-1:0] p1_req_wdata,
    output logic             p1_rsp_valid,
    output logic [WIDTH-1:0] p1_rsp_rdata,
    output logic             p1_rsp_err,
    output logic             mem_w_enable,
    output logic             mem_r_enable,
    output logic [31:0]      mem_addr_select,
    output logic [WIDTH-1:0] mem_data_in,
    input  logic [WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    if (SIZE == 0) begin : g_bad_size
        $error("mem_arbiter: SIZE must be nonzero");
    end

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               cmd_port_q;
    logic               cmd_we_q;
    logic               cmd_err_q;
    logic [31:0]        cmd_addr_q;
    logic [WIDTH-1:0]   cmd_wdata_q;

    logic               grant;
    logic               grant_port;
    logic               grant_we;
    logic               grant_err;
    logic [31:0]        grant_addr;
    logic [WIDTH-1:0]   grant_wdata;
    logic [WIDTH-1:0]   rsp_rdata;

    // Request mux for whichever port the arbiter selects
    always_comb begin
        grant_we    = grant_port ? p1_req_we    : p0_req_we;
        grant_addr  = grant_port ? p1_req_addr  : p0_req_addr;
        grant_wdata = grant_port ? p1_req_wdata : p0_req_wdata;
`ifdef MEM_ARB_BOUND_CHECK_EN
        grant_err   = (grant_addr >= 32'(SIZE));
`else
        grant_err   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Command register, loaded only on a grant so addr/data hold between commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_port_q  <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else if (grant) begin
            cmd_port_q  <= grant_port;
            cmd_we_q    <= grant_we;
            cmd_err_q   <= grant_err;
            cmd_addr_q  <= grant_addr;
            cmd_wdata_q <= grant_wdata;
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        grant           = 1'b0;
        grant_port      = 1'b0;
        rsp_rdata       = '0;
        p0_req_ready    = 1'b0;
        p1_req_ready    = 1'b0;
        p0_rsp_valid    = 1'b0;
        p0_rsp_rdata    = '0;
        p0_rsp_err      = 1'b0;
        p1_rsp_valid    = 1'b0;
        p1_rsp_rdata    = '0;
        p1_rsp_err      = 1'b0;
        mem_w_enable    = 1'b0;
        mem_r_enable    = 1'b0;
        mem_addr_select = cmd_addr_q;
        mem_data_in     = cmd_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (p0_req_valid || p1_req_valid) begin
                    // Pointer breaks ties only; a lone requester always wins
                    grant        = 1'b1;
                    grant_port   = p1_req_valid && (!p0_req_valid || ptr_q);
                    p0_req_ready = !grant_port;
                    p1_req_ready = grant_port;
                    ptr_d        = !grant_port;
                    state_d      = S_CMD;
                end
            end
            S_CMD: begin
                mem_w_enable = cmd_we_q && !cmd_err_q;
                mem_r_enable = !cmd_we_q && !cmd_err_q;
                state_d      = S_RESP;
            end
            S_RESP: begin
                rsp_rdata = (cmd_we_q || cmd_err_q) ? '0 : mem_data_out;
                if (cmd_port_q) begin
                    p1_rsp_valid = 1'b1;
                    p1_rsp_rdata = rsp_rdata;
                    p1_rsp_err   = cmd_err_q;
                end else begin
                    p0_rsp_valid = 1'b1;
                    p0_rsp_rdata = rsp_rdata;
                    p0_rsp_err   = cmd_err_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a behavioural memory and reference model.
module tb_mem_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SIZE  = 128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             p0_req_valid, p0_req_ready, p0_req_we;
    logic [31:0]      p0_req_addr;
    logic [WIDTH-1:0] p0_req_wdata;
    logic             p0_rsp_valid, p0_rsp_err;
    logic [WIDTH-1:0] p0_rsp_rdata;
    logic             p1_req_valid, p1_req_ready, p1_req_we;
    logic [31:0]      p1_req_addr;
    logic [WIDTH-1:0] p1_req_wdata;
    logic             p1_rsp_valid, p1_rsp_err;
    logic [WIDTH-1:0] p1_rsp_rdata;
    logic             mem_w_enable, mem_r_enable;
    logic [31:0]      mem_addr_select;
    logic [WIDTH-1:0] mem_data_in;
    logic [WIDTH-1:0] mem_data_out = '0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Testbench memory (environment) and the model's independent view of its contents
    logic [WIDTH-1:0] mem_arr [0:255];
    logic [WIDTH-1:0] ref_mem [0:255];
    int               ptr;

    mem_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
        .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable),
        .mem_addr_select(mem_addr_select), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_w_enable && mem_addr_select < 256) mem_arr[mem_addr_select[7:0]] <= mem_data_in;
        if (mem_r_enable && mem_addr_select < 256) mem_data_out <= mem_arr[mem_addr_select[7:0]];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oob(input logic [31:0] a);
`ifdef MEM_ARB_BOUND_CHECK_EN
        return a >= SIZE;
`else
        return (a != a);
`endif
    endfunction

    // One full transaction: accept in T, command in T+1, response in T+2
    task automatic run_txn(input bit v0, input bit v1, input bit late1,
                           input bit we0, input bit we1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1);
        int win;
        bit we, oob;
        logic [31:0] a, d, exp_rd;
        @(negedge clk);
        p0_req_valid = v0; p0_req_we = we0; p0_req_addr = a0; p0_req_wdata = d0;
        p1_req_valid = v1 && !late1; p1_req_we = we1; p1_req_addr = a1; p1_req_wdata = d1;
        #1;
        win = (v0 && v1 && !late1) ? ptr : (v0 ? 0 : 1);
        we  = win ? we1 : we0;
        a   = win ? a1 : a0;
        d   = win ? d1 : d0;
        oob = is_oob(a);
        chk("T_p0_ready", 32'(p0_req_ready), 32'(win == 0));
        chk("T_p1_ready", 32'(p1_req_ready), 32'(win == 1));
        @(negedge clk);
        if (late1) p1_req_valid = 1'b1;
        #1;
        chk("T1_ready", 32'({p0_req_ready, p1_req_ready}), 32'd0);
        chk("T1_w_en", 32'(mem_w_enable), 32'(we && !oob));
        chk("T1_r_en", 32'(mem_r_enable), 32'(!we && !oob));
        chk("T1_addr", mem_addr_select, a);
        chk("T1_wdata", mem_data_in, d);
        chk("T1_rsp", 32'({p0_rsp_valid, p1_rsp_valid}), 32'd0);
        @(negedge clk); #1;
        exp_rd = (we || oob) ? 32'd0 : ref_mem[a[7:0]];
        chk("T2_ready", 32'({p0_req_ready, p1_req_ready}), 32'd0);
        chk("T2_en", 32'({mem_w_enable, mem_r_enable}), 32'd0);
        chk("T2_p0_valid", 32'(p0_rsp_valid), 32'(win == 0));
        chk("T2_p1_valid", 32'(p1_rsp_valid), 32'(win == 1));
        chk("T2_p0_rdata", p0_rsp_rdata, (win == 0) ? exp_rd : 32'd0);
        chk("T2_p1_rdata", p1_rsp_rdata, (win == 1) ? exp_rd : 32'd0);
        chk("T2_p0_err", 32'(p0_rsp_err), 32'(win == 0 && oob));
        chk("T2_p1_err", 32'(p1_rsp_err), 32'(win == 1 && oob));
        ptr = 1 - win;
        if (we && !oob) ref_mem[a[7:0]] = d;
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            mem_arr[i] = w;
            ref_mem[i] = w;
        end
        mem_arr[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        p0_req_valid = 0; p0_req_we = 0; p0_req_addr = 0; p0_req_wdata = 0;
        p1_req_valid = 0; p1_req_we = 0; p1_req_addr = 0; p1_req_wdata = 0;
        ptr   = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid,
                                p0_rsp_err, p1_rsp_err, mem_w_enable, mem_r_enable}), 32'd0);
        chk("rst_addr", mem_addr_select, 32'd0);
        chk("rst_data", mem_data_in, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed: read preloaded word, write then read back
        run_txn(1, 0, 0, 0, 0, 32'd5, 32'd0, 32'd0, 32'd0);
        run_txn(0, 1, 0, 0, 1, 32'd0, 32'd9, 32'd0, 32'h12345678);
        run_txn(1, 0, 0, 0, 0, 32'd9, 32'd0, 32'd0, 32'd0);

        // p1 arrives while p0 is in flight and is served next
        run_txn(1, 1, 1, 0, 0, 32'd3, 32'd4, 32'd0, 32'd0);
        run_txn(0, 1, 0, 0, 0, 32'd0, 32'd4, 32'd0, 32'd0);

        // Out-of-range address
        run_txn(1, 0, 0, 0, 0, 32'd200, 32'd0, 32'd0, 32'd0);

        // Reset during RESP of a p0 read
        @(negedge clk);
        p0_req_valid = 1; p0_req_we = 0; p0_req_addr = 32'd5; p1_req_valid = 0;
        #1 chk("rr_ready", 32'(p0_req_ready), 32'd1);
        @(negedge clk);
        p0_req_valid = 0;
        @(negedge clk); #1;
        chk("rr_pre_valid", 32'(p0_rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_valid_drop", 32'(p0_rsp_valid), 32'd0);
        chk("rr_addr_clr", mem_addr_select, 32'd0);
        ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rr_quiet", 32'({p0_rsp_valid, p1_rsp_valid, mem_w_enable, mem_r_enable}), 32'd0);
        end

        // Both valid continuously: p0, p1, p0, p1
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 0, 0, 0, 32'(10 + i), 32'(20 + i), 32'd0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            bit v0, v1;
            logic [31:0] a0, a1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            a0 = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(120, 255)) : 32'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(120, 255)) : 32'($urandom_range(0, 15));
            run_txn(v0, v1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    a0, a1, $urandom, $urandom);
        end

        @(negedge clk);
        p0_req_valid = 0; p1_req_valid = 0;
        #1 chk("end_idle", 32'({p0_req_ready, p1_req_ready}), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
